// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen : fetch-address generator for the IF stage.
//
// Holds the architectural fetch PC and picks the next one from, in priority
// order: reset, global hold (cpu_en low), EX redirect, stall hold, and the
// predicted next PC (BTB target when predicted taken, else pc + 4).
//
// Optional feature macro: BRANCH_PREDICT_EN
//   defined   : flop-based, direct-mapped BTB with 2-bit counters, trained by
//               EX branch-resolution updates.
//   undefined : no BTB storage, predt_br_taken = 0, next PC = pc + 4,
//               btb_upd_* ignored.
//
// Ports
//   clk             in   clock, rising edge
//   rst             in   synchronous active-high reset
//   cpu_en          in   global enable, low holds all state
//   pc_stall        in   hold current PC
//   ex_redirect     in   EX redirect strobe (wins over pc_stall)
//   ex_redirect_pc  in   redirect target, [1:0] forced to 0
//   btb_upd_en      in   BTB update strobe
//   btb_upd_pc      in   PC of resolved branch
//   btb_upd_taken   in   resolved direction
//   btb_upd_target  in   resolved taken target
//   pc              out  current fetch PC (registered)
//   predt_br_taken  out  prediction for pc (combinational from pc + BTB)
// ---------------------------------------------------------------------------
module pc_gen #(
   parameter int unsigned            PC_WIDTH  = 32,
   parameter int unsigned            BTB_DEPTH = 64,
   parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cpu_en,
   input  logic                pc_stall,
   input  logic                ex_redirect,
   input  logic [PC_WIDTH-1:0] ex_redirect_pc,
   input  logic                btb_upd_en,
   input  logic [PC_WIDTH-1:0] btb_upd_pc,
   input  logic                btb_upd_taken,
   input  logic [PC_WIDTH-1:0] btb_upd_target,
   output logic [PC_WIDTH-1:0] pc,
   output logic                predt_br_taken
);

   localparam int unsigned IDX   = (BTB_DEPTH > 1) ? $clog2(BTB_DEPTH) : 1;
   localparam int unsigned TAG_W = PC_WIDTH - IDX - 2;
   localparam int unsigned TGT_W = PC_WIDTH - 2;

   logic [PC_WIDTH-1:0] r_pc;
   logic [PC_WIDTH-1:0] w_pc_next;
   logic [PC_WIDTH-1:0] w_pc_inc;
   logic [PC_WIDTH-1:0] w_pred_next;
   logic                w_pred_taken;
   logic                w_unused;

   // Sequential successor, wraps modulo 2^PC_WIDTH
   assign w_pc_inc = r_pc + PC_WIDTH'(4);

`ifdef BRANCH_PREDICT_EN
   // BTB storage in flops so reset clears every entry in one edge
   logic             r_valid [BTB_DEPTH];
   logic [TAG_W-1:0] r_tag   [BTB_DEPTH];
   logic [TGT_W-1:0] r_tgt   [BTB_DEPTH];
   logic [1:0]       r_ctr   [BTB_DEPTH];

   logic [IDX-1:0]   w_rd_idx;
   logic [TAG_W-1:0] w_rd_tag;
   logic             w_rd_hit;
   logic [IDX-1:0]   w_upd_idx;
   logic [TAG_W-1:0] w_upd_tag;
   logic             w_upd_hit;

   assign w_rd_idx  = r_pc[IDX+1:2];
   assign w_rd_tag  = r_pc[PC_WIDTH-1:IDX+2];
   assign w_upd_idx = btb_upd_pc[IDX+1:2];
   assign w_upd_tag = btb_upd_pc[PC_WIDTH-1:IDX+2];

   // Lookup reads pre-update contents; writes become visible next cycle
   assign w_rd_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
   assign w_pred_taken = w_rd_hit && r_ctr[w_rd_idx][1];
   assign w_pred_next  = w_pred_taken ? {r_tgt[w_rd_idx], 2'b00} : w_pc_inc;

   assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

   // BTB training: saturating 2-bit counter, allocate only on taken miss
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < BTB_DEPTH; i++) begin
            r_valid[i] <= 1'b0;
            r_tag[i]   <= '0;
            r_tgt[i]   <= '0;
            r_ctr[i]   <= 2'b01;
         end
      end else if (cpu_en && btb_upd_en) begin
         if (btb_upd_taken) begin
            if (w_upd_hit) begin
               if (r_ctr[w_upd_idx] != 2'b11) begin
                  r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'd1;
               end
               r_tgt[w_upd_idx] <= btb_upd_target[PC_WIDTH-1:2];
            end else begin
               r_valid[w_upd_idx] <= 1'b1;
               r_tag[w_upd_idx]   <= w_upd_tag;
               r_tgt[w_upd_idx]   <= btb_upd_target[PC_WIDTH-1:2];
               r_ctr[w_upd_idx]   <= 2'b10;
            end
         end else if (w_upd_hit) begin
            if (r_ctr[w_upd_idx] != 2'b00) begin
               r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'd1;
            end
         end
      end
   end

   // Word-offset bits carry no information for the BTB
   assign w_unused = ^{btb_upd_pc[1:0], btb_upd_target[1:0], ex_redirect_pc[1:0]};
`else
   assign w_pred_taken = 1'b0;
   assign w_pred_next  = w_pc_inc;

   // Update port is inert when prediction is compiled out
   assign w_unused = ^{btb_upd_en, btb_upd_pc, btb_upd_taken, btb_upd_target,
                       ex_redirect_pc[1:0]};
`endif

   // Next-PC select: hold > redirect > stall > predicted next
   always_comb begin
      w_pc_next = r_pc;
      if (cpu_en) begin
         if (ex_redirect) begin
            w_pc_next = {ex_redirect_pc[PC_WIDTH-1:2], 2'b00};
         end else if (!pc_stall) begin
            w_pc_next = w_pred_next;
         end
      end
   end

   // Fetch PC register; reset ignores cpu_en
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   assign pc             = r_pc;
   assign predt_br_taken = w_pred_taken;

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen : self-checking bench for pc_gen. A vector table covers reset,
// sequential fetch, stall, redirect and cpu_en; hand-written sequences cover
// BTB training, aliasing, saturation, same-cycle update and reset mid-run.
// Expectations follow BRANCH_PREDICT_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_pc_gen;

   localparam int unsigned PCW = 32;
`ifdef BRANCH_PREDICT_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   logic           clk;
   logic           rst;
   logic           cpu_en;
   logic           pc_stall;
   logic           ex_redirect;
   logic [PCW-1:0] ex_redirect_pc;
   logic           btb_upd_en;
   logic [PCW-1:0] btb_upd_pc;
   logic           btb_upd_taken;
   logic [PCW-1:0] btb_upd_target;
   logic [PCW-1:0] pc;
   logic           predt_br_taken;

   int n_checks = 0;
   int n_errors = 0;

   pc_gen #(.PC_WIDTH(PCW), .BTB_DEPTH(64), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .cpu_en         (cpu_en),
      .pc_stall       (pc_stall),
      .ex_redirect    (ex_redirect),
      .ex_redirect_pc (ex_redirect_pc),
      .btb_upd_en     (btb_upd_en),
      .btb_upd_pc     (btb_upd_pc),
      .btb_upd_taken  (btb_upd_taken),
      .btb_upd_target (btb_upd_target),
      .pc             (pc),
      .predt_br_taken (predt_br_taken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic           rst;
      logic           en;
      logic           stall;
      logic           redir;
      logic [PCW-1:0] rpc;
      logic [PCW-1:0] epc;
      logic           ept;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic r, input logic e, input logic s,
                               input logic d, input logic [PCW-1:0] rp,
                               input logic [PCW-1:0] ep, input logic et);
      vec_t v;
      v.rst = r; v.en = e; v.stall = s; v.redir = d;
      v.rpc = rp; v.epc = ep; v.ept = et;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [PCW-1:0] ep, input logic et);
      n_checks++;
      if (pc !== ep) begin
         n_errors++;
         $display("FAIL %s: pc=%h expected %h", nm, pc, ep);
      end
      n_checks++;
      if (predt_br_taken !== et) begin
         n_errors++;
         $display("FAIL %s: predt_br_taken=%b expected %b", nm, predt_br_taken, et);
      end
   endtask

   task automatic idle();
      rst = 1'b0; cpu_en = 1'b1; pc_stall = 1'b0;
      ex_redirect = 1'b0; ex_redirect_pc = '0;
      btb_upd_en = 1'b0; btb_upd_pc = '0; btb_upd_taken = 1'b0; btb_upd_target = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [PCW-1:0] p, input logic t, input logic [PCW-1:0] g);
      btb_upd_en = 1'b1; btb_upd_pc = p; btb_upd_taken = t; btb_upd_target = g;
   endtask

   task automatic redir(input logic [PCW-1:0] p);
      ex_redirect = 1'b1; ex_redirect_pc = p;
   endtask

   initial begin
      idle();
      rst = 1'b1;

      //            rst   en    stall redir rpc           exp pc        exp pt
      vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0));
      vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0));
      vq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h4,        1'b0));
      vq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        1'b0));
      vq.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h8,        1'b0));
      vq.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h8,        1'b0));
      vq.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h8,        1'b0));
      vq.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h203,      32'h200,      1'b0));
      vq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h300,      32'h200,      1'b0));
      vq.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h200,      1'b0));
      vq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h204,      1'b0));
      vq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h1000,     32'h1000,     1'b0));
      vq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h1004,     1'b0));
      vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0));
      vq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h4,        1'b0));
      vq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0));
      vq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0));

      for (int i = 0; i < vq.size(); i++) begin
         rst = vq[i].rst; cpu_en = vq[i].en; pc_stall = vq[i].stall;
         ex_redirect = vq[i].redir; ex_redirect_pc = vq[i].rpc;
         tick();
         chk($sformatf("vec%0d", i), vq[i].epc, vq[i].ept);
      end

      // Training: taken allocation, then two not-taken updates
      idle(); rst = 1'b1; tick(); tick();
      chk("A_rst", 32'h0, 1'b0);
      rst = 1'b0;
      upd(32'h10, 1'b1, 32'h40); tick();
      chk("A_seq", 32'h4, 1'b0);
      idle(); tick(); tick(); tick();
      chk("A_hit", 32'h10, BP);
      tick();
      chk("A_pred", BP ? 32'h40 : 32'h14, 1'b0);
      upd(32'h10, 1'b0, 32'h0); tick(); tick();
      idle(); redir(32'h10); tick();
      chk("A_nt", 32'h10, 1'b0);
      idle(); tick();
      chk("A_nt_seq", 32'h14, 1'b0);

      // Aliasing: same index, different tag
      idle(); rst = 1'b1; tick(); tick();
      rst = 1'b0;
      upd(32'h10, 1'b1, 32'h40); redir(32'h110); tick();
      chk("B_alias", 32'h110, 1'b0);
      idle(); tick();
      chk("B_alias_seq", 32'h114, 1'b0);
      upd(32'h110, 1'b0, 32'h0); redir(32'h10); tick();
      chk("B_keep", 32'h10, BP);
      idle(); tick();
      chk("B_keep_pred", BP ? 32'h40 : 32'h14, 1'b0);

      // Saturation: four taken then one not-taken must still predict taken
      for (int k = 0; k < 4; k++) begin
         idle(); upd(32'h20, 1'b1, 32'h80); tick();
      end
      idle(); upd(32'h20, 1'b0, 32'h0); tick();
      idle(); redir(32'h20); tick();
      chk("C_sat", 32'h20, BP);
      idle(); tick();
      chk("C_sat_pred", BP ? 32'h80 : 32'h24, 1'b0);

      // Same-cycle update of the entry being looked up (ctr now 10)
      idle(); redir(32'h20); tick();
      chk("D_pre", 32'h20, BP);
      idle(); upd(32'h20, 1'b0, 32'h0); pc_stall = 1'b1; tick();
      chk("D_post", 32'h20, 1'b0);
      idle(); upd(32'h20, 1'b1, 32'h100); tick();
      chk("D_same", 32'h24, 1'b0);
      idle(); redir(32'h20); tick();
      chk("D_pre2", 32'h20, BP);
      idle(); upd(32'h20, 1'b0, 32'h0); tick();
      chk("D_old", BP ? 32'h100 : 32'h24, 1'b0);
      idle(); redir(32'h20); tick();
      chk("D_new", 32'h20, 1'b0);

      // Reset while a trained entry is predicting
      idle(); redir(32'h10); tick();
      chk("E_pre", 32'h10, BP);
      idle(); rst = 1'b1; tick();
      chk("E_rst", 32'h0, 1'b0);
      idle(); redir(32'h10); tick();
      chk("E_cold", 32'h10, 1'b0);
      idle(); tick();
      chk("E_cold_seq", 32'h14, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
